// File: rtl/imem_load_ctrl_if.sv
// Instruction-memory sharing bus: CPU fetch path, loader byte stream
// and instruction-memory read/write ports.
interface imem_load_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  LoadStart;
    logic [8:0]            LoadLen;
    logic                  ByteValid;
    logic [7:0]            ByteIn;
    logic                  ByteReady;
    logic                  LoadDone;
    logic                  CpuStall;
    logic [31:0]           FetchAddr;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [31:0]           ImemRdAddr;
    logic [DATA_WIDTH-1:0] ImemInstr;
    logic                  ImemWrEn;
    logic [ADDR_WIDTH-1:0] ImemWrAddr;
    logic [DATA_WIDTH-1:0] ImemWrData;

    modport master (
        input  LoadStart, LoadLen, ByteValid, ByteIn,
        input  FetchAddr, ImemInstr,
        output ByteReady, LoadDone, CpuStall,
        output Instruction, ImemRdAddr,
        output ImemWrEn, ImemWrAddr, ImemWrData
    );

    modport slave (
        output LoadStart, LoadLen, ByteValid, ByteIn,
        output FetchAddr, ImemInstr,
        input  ByteReady, LoadDone, CpuStall,
        input  Instruction, ImemRdAddr,
        input  ImemWrEn, ImemWrAddr, ImemWrData
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Shares the instruction memory between CPU fetch and a byte-stream
// program loader; the CPU is stalled while a load is in progress.
module imem_load_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    imem_load_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        RUN,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [8:0]            len, len_n;
    logic [1:0]            bcnt, bcnt_n;
    logic [ADDR_WIDTH-1:0] waddr, waddr_n;
    logic [DATA_WIDTH-1:0] word, word_n;
    logic                  last;

    assign last = (9'(waddr) == len - 9'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len   <= '0;
            bcnt  <= '0;
            waddr <= '0;
            word  <= '0;
        end else begin
            len   <= len_n;
            bcnt  <= bcnt_n;
            waddr <= waddr_n;
            word  <= word_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        bcnt_n  = bcnt;
        waddr_n = waddr;
        word_n  = word;
        unique case (state)
            RUN: begin
                if (bus.LoadStart && bus.LoadLen != 9'd0) begin
                    len_n   = (bus.LoadLen > 9'd256) ? 9'd256 : bus.LoadLen;
                    bcnt_n  = '0;
                    waddr_n = '0;
                    word_n  = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                // Shift in from the top so the first byte lands in [7:0].
                if (bus.ByteValid && bus.ByteReady) begin
                    word_n = {bus.ByteIn, word[DATA_WIDTH-1:8]};
                    bcnt_n = bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last) begin
                    state_n = DONE;
                end else begin
                    waddr_n = waddr + ADDR_WIDTH'(1);
                    bcnt_n  = '0;
                    state_n = LOAD;
                end
            end
            DONE: begin
                state_n = RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    assign bus.ImemRdAddr  = bus.FetchAddr;
    assign bus.Instruction = (state == RUN) ? bus.ImemInstr : '0;
    assign bus.CpuStall    = (state != RUN);
    assign bus.ByteReady   = (state == LOAD);
    assign bus.ImemWrEn    = (state == WRITE);
    assign bus.LoadDone    = (state == DONE);
    assign bus.ImemWrAddr  = waddr;
    assign bus.ImemWrData  = word;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed and randomized loads
// checked against a byte-list-to-word model of the loader.
module tb_imem_load_ctrl;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    imem_load_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    imem_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int ncyc = 0;
    int done_cnt = 0;
    int done_at = -1;
    int last_wr_at = -1;
    int stall_bad = 0;
    bit prev_done = 1'b0;

    // Observe the memory write port and LoadDone away from the active edge.
    always @(negedge clk) begin
        ncyc++;
        if (bus.ImemWrEn === 1'b1) begin
            wr_addr_q.push_back(32'(bus.ImemWrAddr));
            wr_data_q.push_back(bus.ImemWrData);
            last_wr_at = ncyc;
            if (bus.CpuStall !== 1'b1) stall_bad++;
        end
        if (bus.LoadDone === 1'b1) begin
            done_cnt++;
            done_at = ncyc;
        end
        if (prev_done && bus.CpuStall !== 1'b0) stall_bad++;
        prev_done = (bus.LoadDone === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pat: 0 random bytes, 1 incrementing, 2 fixed 78 56 34 12 EF BE AD DE
    // mode: 0 continuous, 1 every third cycle, 2 random valid
    task automatic run_load(input int ll, input int mode, input int pat,
                            input bit midstart, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] fixed[8];
        logic [31:0] exp_w;
        int leff, bi, cyc, budget, nop_bad, wbase, dbase, sbase, nw;
        bit v, take;
        fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        leff = (ll > 256) ? 256 : ll;
        bi = 0;
        cyc = 0;
        nop_bad = 0;
        budget = leff * 20 + 40;
        for (int i = 0; i < 4 * leff; i++) begin
            case (pat)
                1: bytes.push_back(8'(i));
                2: bytes.push_back(fixed[i % 8]);
                default: bytes.push_back(8'($urandom));
            endcase
        end
        wbase = wr_addr_q.size();
        dbase = done_cnt;
        sbase = stall_bad;

        @(posedge clk); #1;
        bus.LoadStart = 1'b1;
        bus.LoadLen = 9'(ll);
        @(posedge clk); #1;
        bus.LoadStart = 1'b0;
        bus.LoadLen = 9'($urandom);
        while (bus.CpuStall === 1'b1 && cyc < budget) begin
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.ByteValid = v;
            bus.ByteIn = (bi < bytes.size()) ? bytes[bi] : 8'($urandom);
            bus.ImemInstr = $urandom | 32'h1;
            bus.LoadStart = midstart && (cyc == 7);
            bus.LoadLen = 9'd5;
            #1;
            if (bus.Instruction !== 32'h0) nop_bad++;
            take = v && (bus.ByteReady === 1'b1);
            @(posedge clk); #1;
            cyc++;
            if (take) bi++;
        end
        bus.ByteValid = 1'b0;
        bus.LoadStart = 1'b0;

        chk({tag, " finished in budget"}, 64'(cyc < budget), 64'd1);
        chk({tag, " bytes consumed"}, 64'(bi), 64'(4 * leff));
        nw = wr_addr_q.size() - wbase;
        chk({tag, " write count"}, 64'(nw), 64'(leff));
        for (int i = 0; i < leff && i < nw; i++) begin
            exp_w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            chk({tag, " write addr"}, 64'(wr_addr_q[wbase+i]), 64'(i));
            chk({tag, " write data"}, 64'(wr_data_q[wbase+i]), 64'(exp_w));
        end
        chk({tag, " LoadDone pulses"}, 64'(done_cnt - dbase), 64'd1);
        chk({tag, " LoadDone after last write"},
            64'(done_at - last_wr_at), 64'd1);
        chk({tag, " stall around write/done"}, 64'(stall_bad - sbase), 64'd0);
        chk({tag, " NOP during load"}, 64'(nop_bad), 64'd0);
        chk({tag, " CPU released"}, 64'(bus.CpuStall), 64'd0);
        if (mode == 0) chk({tag, " load latency"}, 64'(cyc), 64'(5 * leff + 1));
    endtask

    initial begin
        int wb, db;
        bus.LoadStart = 1'b0;
        bus.LoadLen = '0;
        bus.ByteValid = 1'b0;
        bus.ByteIn = '0;
        bus.FetchAddr = '0;
        bus.ImemInstr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.FetchAddr = 32'd5;
        bus.ImemInstr = 32'h2008_0001;
        #1;
        chk("reset rdaddr", 64'(bus.ImemRdAddr), 64'd5);
        chk("reset instr", 64'(bus.Instruction), 64'h2008_0001);
        chk("reset stall", 64'(bus.CpuStall), 64'd0);
        chk("reset byteready", 64'(bus.ByteReady), 64'd0);
        chk("reset wren", 64'(bus.ImemWrEn), 64'd0);
        chk("reset done", 64'(bus.LoadDone), 64'd0);
        chk("reset wraddr", 64'(bus.ImemWrAddr), 64'd0);
        chk("reset wrdata", 64'(bus.ImemWrData), 64'd0);

        run_load(2, 0, 2, 1'b0, "stream");
        run_load(2, 1, 2, 1'b0, "third");

        wb = wr_addr_q.size();
        db = done_cnt;
        @(posedge clk); #1;
        bus.LoadStart = 1'b1;
        bus.LoadLen = 9'd2;
        @(posedge clk); #1;
        bus.LoadStart = 1'b0;
        bus.ByteValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ByteIn = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.ByteValid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst stall", 64'(bus.CpuStall), 64'd0);
        chk("midrst byteready", 64'(bus.ByteReady), 64'd0);
        chk("midrst wren", 64'(bus.ImemWrEn), 64'd0);
        chk("midrst wrdata", 64'(bus.ImemWrData), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst no writes", 64'(wr_addr_q.size() - wb), 64'd0);
        chk("midrst no done", 64'(done_cnt - db), 64'd0);
        run_load(1, 0, 0, 1'b0, "afterrst");

        bus.LoadStart = 1'b1;
        bus.LoadLen = 9'd0;
        @(posedge clk); #1;
        bus.LoadStart = 1'b0;
        @(posedge clk); #1;
        chk("len0 stall", 64'(bus.CpuStall), 64'd0);
        chk("len0 byteready", 64'(bus.ByteReady), 64'd0);

        run_load(300, 0, 1, 1'b0, "len300");
        chk("len300 last addr", 64'(wr_addr_q[$]), 64'd255);

        run_load(3, 2, 0, 1'b1, "midstart");
        for (int n = 0; n < 4; n++) begin
            run_load($urandom_range(1, 6), 2, 0, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
